// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - UART TX byte handshake between arbiter and transmitter
//
// Signals:
//   tx_data  : byte offered to the transmitter (master -> slave)
//   tx_valid : tx_data is valid (master -> slave)
//   tx_ready : transmitter can accept a byte (slave -> master)
//   tx_done  : one-cycle pulse when the frame has left the line (slave -> master)
// Modports: master = arbiter side, slave = UART transmitter side.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   req_valid  : per-requester byte pending
//   req_data   : requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  : one-hot grant (combinational, only in IDLE)
//   req_done   : one-cycle pulse when the granted requester's frame completes
//   busy       : arbiter is not in IDLE
//   grant_id   : index of the current or last granted requester
//   tx         : UART TX handshake (master modport of uart_tx_arbiter_if)
// Configuration:
//   UART_ARB_FIXED_PRIO_EN : when defined, lowest-index valid requester always
//                            wins and the round-robin pointer is held at 0.
module uart_tx_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id,
  uart_tx_arbiter_if.master             tx
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            found;
  int              idx;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Search always starts at requester 0, so the pointer is a constant.
  assign rr_ptr = '0;
`else
`endif

  // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_id    <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= 1'b0;
      req_done    <= '0;
`ifdef UART_ARB_FIXED_PRIO_EN
`else
      rr_ptr      <= '0;
`endif
    end else begin
      req_done <= '0;
      case (state)
        IDLE: begin
          // A valid winner in IDLE is always accepted (req_ready is high for it).
          if (found) begin
            tx.tx_data  <= req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            grant_id    <= winner;
            tx.tx_valid <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (tx.tx_ready) begin
            tx.tx_valid <= 1'b0;
            state       <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx.tx_done) begin
            req_done[grant_id] <= 1'b1;
`ifdef UART_ARB_FIXED_PRIO_EN
`else
            rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a transaction-level model
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic        busy;
  logic [1:0]  grant_id;

  int checks   = 0;
  int failures = 0;

  int         m_ptr        = 0;
  logic [3:0] pending_done = 4'b0000;

  uart_tx_arbiter_if #(.DATA_WIDTH(8)) tx_if ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .req_done  (req_done),
    .busy      (busy),
    .grant_id  (grant_id),
    .tx        (tx_if.master)
  );

  always #5 clk = ~clk;

  // Reference arbitration: who should win a given request mask.
  function automatic int model_pick(input logic [3:0] m);
    int base;
`ifdef UART_ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = m_ptr;
`endif
    for (int k = 0; k < 4; k++) begin
      if (m[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b0000;
    tx_if.tx_ready = 1'b0;
    tx_if.tx_done = 1'b0;
    #1;
    checks++; if (tx_if.tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid: got %b expected 0", tx_if.tx_valid); end
    checks++; if (tx_if.tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data: got %h expected 00", tx_if.tx_data); end
    checks++; if (req_done !== 4'b0000) begin failures++; $display("FAIL rst_req_done: got %b expected 0000", req_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant_id: got %0d expected 0", grant_id); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    pending_done = 4'b0000;
  endtask

  // One complete frame: accept, bp cycles of backpressure, tx_done dly cycles
  // into WAIT_DONE. Returns after driving tx_done; the done pulse is checked
  // in the next cycle by whoever runs next (frame or idle_check).
  task automatic do_frame(input logic [3:0] mask, input logic [31:0] data,
                          input int bp, input int dly, input bit drop,
                          output int got_grant);
    int w;
    logic [7:0] b;
    logic [3:0] exp_rdy;
    @(negedge clk);
    tx_if.tx_done = 1'b0;
    req_valid = mask;
    req_data = data;
    tx_if.tx_ready = (bp == 0);
    #1;
    checks++; if (req_done !== pending_done) begin failures++; $display("FAIL done_pulse: req_done=%b expected %b", req_done, pending_done); end
    pending_done = 4'b0000;
    w = model_pick(mask);
    b = data[w*8 +: 8];
    exp_rdy = 4'b0001 << w;
    checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL grant_onehot: req_ready=%b expected %b", req_ready, exp_rdy); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: busy=%b expected 0", busy); end
    got_grant = -1;
    for (int c = 0; c <= bp; c++) begin
      @(negedge clk);
      if (c == 0 && drop) req_valid[w] = 1'b0;
      if (c == 0) req_valid = req_valid | 4'($urandom_range(0, 15));
      if (drop) req_valid[w] = 1'b0;
      tx_if.tx_ready = (c == bp);
      #1;
      if (c == 0) got_grant = int'(grant_id);
      checks++; if (tx_if.tx_valid !== 1'b1) begin failures++; $display("FAIL tx_valid_held: got %b expected 1 (cycle %0d)", tx_if.tx_valid, c); end
      checks++; if (tx_if.tx_data !== b) begin failures++; $display("FAIL tx_data: got %h expected %h", tx_if.tx_data, b); end
      checks++; if (grant_id !== 2'(w)) begin failures++; $display("FAIL grant_id: got %0d expected %0d", grant_id, w); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL send_busy: got %b expected 1", busy); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL no_grant_busy: req_ready=%b expected 0000", req_ready); end
    end
    for (int c = 0; c <= dly; c++) begin
      @(negedge clk);
      tx_if.tx_ready = 1'($urandom_range(0, 1));
      tx_if.tx_done = (c == dly);
      #1;
      checks++; if (tx_if.tx_valid !== 1'b0) begin failures++; $display("FAIL tx_valid_drop: got %b expected 0", tx_if.tx_valid); end
      checks++; if (req_done !== 4'b0000) begin failures++; $display("FAIL early_done: req_done=%b expected 0000", req_done); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wait_busy: got %b expected 1", busy); end
    end
`ifndef UART_ARB_FIXED_PRIO_EN
    m_ptr = (w + 1) % 4;
`endif
    pending_done = exp_rdy;
  endtask

  task automatic idle_check();
    @(negedge clk);
    tx_if.tx_done = 1'b0;
    req_valid = 4'b0000;
    #1;
    checks++; if (req_done !== pending_done) begin failures++; $display("FAIL idle_done: req_done=%b expected %b", req_done, pending_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy_fall: got %b expected 0", busy); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL idle_ready: got %b expected 0000", req_ready); end
    pending_done = 4'b0000;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_single_request();
    int g;
    apply_reset();
    do_frame(4'b0100, {8'h3C, 8'hA5, 8'h5A, 8'hC3}, 0, 19, 1'b0, g);
    idle_check();
    checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_grant_id: got %0d expected 2", grant_id); end
  endtask

  task automatic test_round_robin();
    int g;
    int exp_seq[5];
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_frame(4'b1111, 32'h13121110, 0, $urandom_range(0, 3), 1'b0, g);
      checks++; if (g !== exp_seq[i]) begin failures++; $display("FAIL rr_order: frame %0d grant %0d expected %0d", i, g, exp_seq[i]); end
    end
    idle_check();
  endtask

  task automatic test_backpressure();
    int g;
    do_frame(4'($urandom_range(1, 15)), $urandom, 5, 3, 1'b0, g);
    idle_check();
  endtask

  task automatic test_spurious_done_and_drop();
    int g;
    @(negedge clk);
    req_valid = 4'b0000;
    tx_if.tx_done = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spurious_busy: got %b expected 0", busy); end
    @(negedge clk);
    tx_if.tx_done = 1'b0;
    #1;
    checks++; if (req_done !== 4'b0000) begin failures++; $display("FAIL spurious_done: req_done=%b expected 0000", req_done); end
    checks++; if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin failures++; $display("FAIL spurious_state: busy=%b tx_valid=%b expected 0 0", busy, tx_if.tx_valid); end
    do_frame(4'b1111, $urandom, 1, 2, 1'b1, g);
    do_frame(4'($urandom_range(1, 15)), $urandom, 0, 0, 1'b1, g);
    idle_check();
  endtask

  task automatic test_reset_mid_frame();
    int g;
    @(negedge clk);
    req_valid = 4'b1000;
    req_data = 32'hEE000000;
    tx_if.tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1 || tx_if.tx_valid !== 1'b0) begin failures++; $display("FAIL reach_wait_done: busy=%b tx_valid=%b expected 1 0", busy, tx_if.tx_valid); end
    apply_reset();
    do_frame(4'b1111, 32'h44332211, 0, 1, 1'b0, g);
    checks++; if (g !== 0) begin failures++; $display("FAIL post_reset_grant: got %0d expected 0", g); end
    idle_check();
  endtask

  task automatic test_back_to_back_random();
    int g;
    for (int i = 0; i < 30; i++) begin
      do_frame(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3),
               $urandom_range(0, 4), 1'($urandom_range(0, 1)), g);
    end
    idle_check();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 4'b0000;
    req_data = 32'h0;
    tx_if.tx_ready = 1'b0;
    tx_if.tx_done = 1'b0;
    test_reset();
    test_single_request();
    test_round_robin();
    test_backpressure();
    test_spurious_done_and_drop();
    test_reset_mid_frame();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing one UART transmitter among `NUM_REQ` byte producers. Each requester holds a valid/data pair. The arbiter grants one requester, latches its byte, drives the UART TX handshake (`tx_data`/`tx_valid`/`tx_ready`), and waits for the frame-complete pulse `tx_done`. It then returns a per-requester done pulse and moves to the next requester. It sits between software/DMA byte sources and the `tx_*` interface of the UART top level.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `DATA_WIDTH`, 8, byte width; matches the UART data width
- `clk` in 1: system clock
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in `NUM_REQ`: requester i has a byte pending
- `req_data` in `NUM_REQ*DATA_WIDTH`: requester i byte at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_ready` out `NUM_REQ`: one-hot grant; a byte is accepted when `req_valid[i] & req_ready[i]`
- `req_done` out `NUM_REQ`: one-cycle pulse when requester i's frame finishes on the line
- `tx_data` out `DATA_WIDTH`: byte to UART TX
- `tx_valid` out 1: byte valid to UART TX
- `tx_ready` in 1: UART TX can accept
- `tx_done` in 1: UART TX frame complete (one-cycle pulse)
- `busy` out 1: arbiter not in IDLE
- `grant_id` out `$clog2(NUM_REQ)`: index of the current or last granted requester

## Operation
- FSM states: IDLE, SEND, WAIT_DONE.
- **IDLE**
  - Winner = first i with `req_valid[i]` set, searching `rr_ptr, rr_ptr+1, …` modulo `NUM_REQ`.
  - `req_ready` is combinational: one-hot on the winner when in IDLE and any `req_valid` is set; all zeros otherwise.
  - On transfer: latch the winner's byte into `tx_data`, set `grant_id` = winner, go to SEND.
- **SEND**
  - `tx_valid`=1, `tx_data` held stable.
  - When `tx_valid & tx_ready`: clear `tx_valid`, go to WAIT_DONE.
- **WAIT_DONE**
  - On `tx_done`: pulse `req_done[grant_id]` for one cycle, set `rr_ptr` = (`grant_id`+1) mod `NUM_REQ`, go to IDLE.
- `tx_done` is ignored outside WAIT_DONE.
- `req_valid` changes after acceptance do not affect the frame in flight; the byte is latched.
- Pointer wrap: `grant_id` = `NUM_REQ`-1 → `rr_ptr` = 0.
- `busy` = (state != IDLE).
- Only one frame is outstanding at a time. No requester is granted while busy.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `grant_id`=0, `tx_data`=0, `tx_valid`=0, `req_done`=0, `busy`=0. `req_ready`=0 because no valid input is present.
- Reset mid-frame (any state) aborts immediately. No `req_done` is issued.
- Cycle timing:
  - Accept in cycle N → `tx_valid`=1 from cycle N+1.
  - If `tx_ready` is high in N+1, `tx_valid`=0 from N+2.
  - `tx_done` in cycle M → `req_done` pulse in M+1, state IDLE in M+1.
  - Next grant is possible in M+1. The minimum gap between a `tx_done` and the next acceptance is 1 cycle.
- `tx_valid` stays asserted across any number of cycles with `tx_ready` low. `tx_data` is stable throughout.
- Simultaneous requests are resolved purely by `rr_ptr`. There is no starvation: every valid requester is served within `NUM_REQ` frames.

## Configuration
- `UART_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. The lowest-index valid requester always wins, and `rr_ptr` is neither used nor updated (stays 0).
  - Undefined (default): round-robin as described above.

## Test plan
- **Single request:** reset, `req_valid`=4'b0100, `req_data[23:16]`=8'hA5, `tx_ready`=1 → `req_ready`=4'b0100 one cycle; `tx_valid` one cycle with `tx_data`=8'hA5; `tx_done` after 20 cycles → `req_done`=4'b0100 next cycle; `grant_id`=2; `busy` falls with the pulse.
- **Round-robin order:** all four valid continuously with bytes 8'h10/11/12/13 → UART sees 10,11,12,13,10 and `grant_id` wraps 3→0 (macro undefined).
- **Fixed priority:** same stimulus with `UART_ARB_FIXED_PRIO_EN` defined → UART sees 10,10,10…; requesters 1–3 are never granted while requester 0 stays valid.
- **Backpressure:** `tx_ready`=0 for 5 cycles after grant → `tx_valid` held 6 cycles; `tx_data` constant; transfer on the first `tx_ready`=1.
- **Spurious done / valid drop:** `tx_done` pulsed in IDLE → no `req_done` and no state change. Requester drops `req_valid` after acceptance → frame still completes and its `req_done` still fires.
- **Reset mid-frame:** assert `rst_n`=0 in WAIT_DONE → all outputs at reset values immediately. After release, requester 0 is granted first.
